// File: rtl/sine_pkg.sv
// Shared constants, arctangent table and FSM state type for the CORDIC sine engine.
package sine_pkg;

  localparam int unsigned IterDefault = 16;
  localparam int unsigned IwDefault   = 20;
  localparam int unsigned GuardBits   = 4;
  localparam int unsigned AtanEntries = 18;
  localparam int unsigned AtanIdxW    = $clog2(AtanEntries);

  // CORDIC gain compensation K = 0.6072529 scaled by 2^18
  localparam logic [19:0] KInit = 20'h26DD4;

  localparam logic [15:0] QuarterAngle = 16'h4000;
  localparam logic [15:0] HalfAngle    = 16'h8000;
  localparam logic [15:0] NegQuarter   = 16'hC000;

  // round(atan(2^-i) / 360 deg * 2^20)
  localparam logic [19:0] AtanLut [AtanEntries] = '{
    20'h20000, 20'h12E40, 20'h09FB4, 20'h05111, 20'h028B1, 20'h0145D,
    20'h00A2F, 20'h00518, 20'h0028C, 20'h00146, 20'h000A3, 20'h00051,
    20'h00029, 20'h00014, 20'h0000A, 20'h00005, 20'h00003, 20'h00001
  };

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/sine_atan_rom.sv
// Combinational arctangent lookup: iteration index to atan_i in 2^20-per-turn units.
module sine_atan_rom
  import sine_pkg::*;
#(
  parameter int unsigned IW   = IwDefault,
  parameter int unsigned IdxW = AtanIdxW
) (
  input  logic [IdxW-1:0] idx_i,
  output logic [IW-1:0]   atan_o
);

  always_comb begin
    atan_o = '0;
    if (32'(idx_i) < AtanEntries) begin
      atan_o = IW'(AtanLut[idx_i]);
    end
  end

endmodule

// File: rtl/sine.sv
// Iterative CORDIC sine generator, one micro-rotation per clock.
// Define SINE_COS_EN to add a Cos_o output derived from the x register.
module sine
  import sine_pkg::*;
#(
  parameter int unsigned ITER = IterDefault,
  parameter int unsigned IW   = IwDefault
) (
  input  logic        Clk_i,
  input  logic        Rst_i,
  input  logic [15:0] Angle_i,
  input  logic        Start_i,
  output logic [15:0] Sine_o,
`ifdef SINE_COS_EN
  output logic [15:0] Cos_o,
`endif
  output logic        Done_o
);

  localparam int unsigned CntW = AtanIdxW;
  localparam logic signed [IW:0] RoundBias = (IW+1)'(1 << (GuardBits - 1));
  localparam logic signed [IW:0] SatHi     = (IW+1)'(16384);
  localparam logic signed [IW:0] SatLo     = -SatHi;

  state_e               state_q, state_d;
  logic [15:0]          angle_q, angle_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic signed [IW-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [15:0]          sine_q, sine_d;
  logic                 done_q, done_d;
`ifdef SINE_COS_EN
  logic [15:0]          cos_q, cos_d;
  logic                 refl_q, refl_d;
`endif

  logic                 reflect;
  logic [15:0]          s_fold;
  logic signed [IW-1:0] x_sh, y_sh;
  logic [IW-1:0]        atan;

  sine_atan_rom #(
    .IW   (IW),
    .IdxW (CntW)
  ) u_atan_rom (
    .idx_i  (cnt_q),
    .atan_o (atan)
  );

  // Round-half-up of the guard bits, then clamp to +/-1.0 in Q2.14
  function automatic logic [15:0] round_sat(input logic signed [IW-1:0] v);
    logic signed [IW:0] r;
    r = $signed({v[IW-1], v}) + RoundBias;
    r = r >>> GuardBits;
    if (r > SatHi) return QuarterAngle;
    if (r < SatLo) return NegQuarter;
    return r[15:0];
  endfunction

  // Angles beyond +/-90 deg are mirrored about +/-90 deg; sin is unchanged.
  // 0x8000 - s covers both the positive and negative reflection modulo 2^16.
  always_comb begin
    reflect = ($signed(angle_q) > $signed(QuarterAngle)) ||
              ($signed(angle_q) < $signed(NegQuarter));
    s_fold  = reflect ? (HalfAngle - angle_q) : angle_q;
    x_sh    = x_q >>> cnt_q;
    y_sh    = y_q >>> cnt_q;
  end

  always_comb begin
    state_d = state_q;
    angle_d = angle_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    sine_d  = sine_q;
    done_d  = 1'b0;
`ifdef SINE_COS_EN
    cos_d   = cos_q;
    refl_d  = refl_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (Start_i) begin
          angle_d = Angle_i;
          state_d = StLoad;
        end
      end
      StLoad: begin
        x_d     = IW'(KInit);
        y_d     = '0;
        z_d     = {{(IW-16){s_fold[15]}}, s_fold} <<< GuardBits;
        cnt_d   = '0;
`ifdef SINE_COS_EN
        refl_d  = reflect;
`endif
        state_d = StRun;
      end
      StRun: begin
        if (!z_q[IW-1]) begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - $signed(atan);
        end else begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + $signed(atan);
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(ITER - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        sine_d  = round_sat(y_q);
`ifdef SINE_COS_EN
        // cos changes sign in the mirrored half-plane
        cos_d   = refl_q ? (16'h0 - round_sat(x_q)) : round_sat(x_q);
`endif
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk_i) begin
    if (!Rst_i) begin
      state_q <= StIdle;
      angle_q <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      sine_q  <= '0;
      done_q  <= 1'b0;
`ifdef SINE_COS_EN
      cos_q   <= '0;
      refl_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      angle_q <= angle_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      sine_q  <= sine_d;
      done_q  <= done_d;
`ifdef SINE_COS_EN
      cos_q   <= cos_d;
      refl_q  <= refl_d;
`endif
    end
  end

  assign Sine_o = sine_q;
  assign Done_o = done_q;
`ifdef SINE_COS_EN
  assign Cos_o  = cos_q;
`endif

endmodule

// File: tb/tb_sine.sv
// Directed bench for the CORDIC sine engine with a queue-based scoreboard of ideal results.
module tb_sine;

  localparam int Latency = 18;
  localparam int Tol     = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] angle;
  logic        start;
  logic [15:0] sine_out;
  logic        done;
`ifdef SINE_COS_EN
  logic [15:0] cos_out;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  int          exp_q[$];
  logic [15:0] ang_q[$];
  logic [15:0] last_sine;

  always #5 clk = ~clk;

  sine dut (
    .Clk_i   (clk),
    .Rst_i   (rst_n),
    .Angle_i (angle),
    .Start_i (start),
    .Sine_o  (sine_out),
`ifdef SINE_COS_EN
    .Cos_o   (cos_out),
`endif
    .Done_o  (done)
  );

  function automatic int ideal_sin(input logic [15:0] a);
    real r;
    r = $sin(6.283185307179586 * real'(a) / 65536.0) * 16384.0;
    if (r >= 0.0) return $rtoi(r + 0.5);
    return -$rtoi(-r + 0.5);
  endfunction

  task automatic check_eq(input string tag, input int obs, input int exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_tol(input string tag, input logic [15:0] a, input int obs, input int exp);
    int diff;
    diff = obs - exp;
    if (diff < 0) diff = -diff;
    tests_run++;
    assert ((diff <= Tol) === 1'b1) else begin
      tests_failed++;
      $error("FAIL %s angle=0x%04h: observed %0d expected %0d +/-%0d", tag, a, obs, exp, Tol);
    end
  endtask

  task automatic start_op(input logic [15:0] a, input bit push);
    @(negedge clk);
    angle = a;
    start = 1'b1;
    if (push) begin
      exp_q.push_back(ideal_sin(a));
      ang_q.push_back(a);
    end
    @(negedge clk);
    start = 1'b0;
    angle = 16'($urandom);
  endtask

  // Bounded wait for Done_o, then score the result and check the pulse width
  task automatic wait_done(input string tag, input bit check_lat);
    int          cyc;
    bit          seen;
    int          e;
    int          s;
    logic [15:0] a;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 3 * Latency) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1'b1;
    end
    check_eq({tag, "_done_seen"}, int'(seen), 1);
    if (seen) begin
      if (check_lat) check_eq({tag, "_latency"}, cyc, Latency);
      s = int'($signed(sine_out));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = ang_q.pop_front();
        check_tol(tag, a, s, e);
      end else begin
        check_eq({tag, "_sb_nonempty"}, 0, 1);
      end
      check_eq({tag, "_in_range"}, int'(s >= -16384 && s <= 16384), 1);
      last_sine = sine_out;
      @(negedge clk);
      check_eq({tag, "_done_width"}, int'(done), 0);
    end
  endtask

  task automatic no_done(input string tag, input int n);
    int cnt;
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check_eq(tag, cnt, 0);
  endtask

  initial begin
    logic [15:0] a;
    rst_n = 1'b0;
    start = 1'b0;
    angle = 16'h0000;
    repeat (3) @(negedge clk);
    check_eq("reset_sine", int'(sine_out), 0);
    check_eq("reset_done", int'(done), 0);
    rst_n = 1'b1;

    start_op(16'h2000, 1'b1);
    wait_done("deg45", 1'b1);
    start_op(16'h4000, 1'b1);
    wait_done("deg90", 1'b1);
    start_op(16'h0000, 1'b1);
    wait_done("deg0", 1'b1);
    start_op(16'hC000, 1'b1);
    wait_done("deg270", 1'b1);
    start_op(16'hA000, 1'b1);
    wait_done("deg225", 1'b1);
    start_op(16'h6000, 1'b1);
    wait_done("deg135", 1'b1);

    // Second start mid-run must be dropped; result stays that of 45 deg
    start_op(16'h2000, 1'b1);
    repeat (5) @(negedge clk);
    start_op(16'hE000, 1'b0);
    wait_done("ignore_start", 1'b0);
    no_done("ignore_no_second_done", 2 * Latency);

    // Abort mid-run; Sine_o holds the previous result until reset clears it
    start_op(16'h1234, 1'b0);
    repeat (8) @(negedge clk);
    check_eq("hold_during_run", int'(sine_out), int'(last_sine));
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("abort_sine", int'(sine_out), 0);
    check_eq("abort_done", int'(done), 0);
    rst_n = 1'b1;
    no_done("abort_no_done", 2 * Latency);
    start_op(16'h2000, 1'b1);
    wait_done("after_abort", 1'b1);

    for (int i = 0; i < 1024; i++) begin
      a = 16'(i * 64 + int'($urandom_range(0, 63)));
      start_op(a, 1'b1);
      wait_done("sweep", 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sine.md
Name: sine

Overview:
- Iterative CORDIC sine generator in rotation mode.
- Accepts a 16-bit binary angle on a Start_i strobe and runs ITER micro-rotations, one per clock.
- Presents a signed fixed-point sine with a one-cycle Done_o pulse.
- Used as a shared trig engine by DSP/datapath blocks that tolerate a fixed multi-cycle latency.

Parameters:
- ITER, 16, number of CORDIC iterations (legal 8..18); also sets latency.
- IW, 20, internal signed width of x/y/z datapath (4 guard fraction bits beyond I/O).

Ports:
- Clk_i  in  1  clock; all logic on rising edge.
- Rst_i  in  1  synchronous, active-low reset.
- Angle_i  in  16  unsigned binary angle: 0x0000=0°, 0x4000=90°, 0x8000=180°, wraps at 0x10000=360°.
- Start_i  in  1  start request, sampled only in IDLE.
- Sine_o  out  16  signed Q2.14 result: 0x4000=+1.0, 0xC000=−1.0.
- Done_o  out  1  one-cycle pulse when Sine_o is updated.

Behaviour:
- Reset (Rst_i=0 at an edge): state IDLE, Sine_o=0, Done_o=0, iteration counter=0. Reset mid-operation aborts the computation; no Done_o is produced.
- States:
  - IDLE: Start_i=1 latches Angle_i → LOAD.
  - LOAD: performs the quadrant fold and initialises x/y/z → RUN.
  - RUN: one micro-rotation per cycle for i=0..ITER−1 → DONE.
  - DONE: writes Sine_o, drives Done_o=1 for exactly one cycle → IDLE.
- Latency: Start_i accepted at edge N gives Done_o high during the cycle after edge N+ITER+2 (ITER=16 → 18 cycles). Back-to-back starts are accepted in the cycle after Done_o.
- Start_i while not in IDLE is ignored, with no queuing. Angle_i is only sampled with the accepted start.
- Quadrant fold: treat the angle as signed s (−180°..+180°).
  - If s > 0x4000: s' = 0x8000 − s.
  - If s < −0x4000: s' = −0x8000 − s.
  - Otherwise s' = s.
  - sin(s') = sin(s), so no output negation is needed.
- Init: z = s' sign-extended with 4 fraction bits (IW bits), y = 0, x = K·2^18 = 159188 (0x26DD4), where K = 0.6072529.
- Iteration i:
  - d = sign(z) (z ≥ 0 → +1).
  - x ← x − d·(y>>>i); y ← y + d·(x>>>i); z ← z − d·atan_i.
  - atan_i = round(atan(2^−i)/360°·2^20). Shifts are arithmetic.
- Output: Sine_o = round(y >>> 4), saturated to [0xC000, 0x4000].
- Accuracy: |error| ≤ 4 LSB vs ideal round(sin·16384) over all 65536 angles.
- Sine_o holds its last value between operations.

Optional Feature:
- Macro SINE_COS_EN.
- Defined: adds output port Cos_o (16-bit, Q2.14), updated alongside Sine_o from the x register with the same rounding and saturation. The fold in that case reflects around ±90° and negates cosine for the reflected quadrants.
- Undefined: no Cos_o port; x is only internal.

Decomposition:
- Package sine_pkg holds:
  - ITER/IW defaults
  - K init constant 0x26DD4
  - the atan LUT constant array (0x20000, 0x12E40, 0x09FB4, ...)
  - the state enum (IDLE, LOAD, RUN, DONE)
  - quarter/half angle constants 0x4000/0x8000
- One sub-module: sine_atan_rom (combinational index → atan_i).

Test Plan:
- Angle_i=0x2000 (45°), Start_i for 1 cycle → Done_o after 18 cycles, Sine_o=0x2D41 ±4.
- Angle_i=0x4000 → Sine_o=0x4000 (saturated); 0x0000 → 0x0000 ±4; 0xC000 → 0xC000.
- Angle_i=0xA000 (225°) → Sine_o=0xD2BF ±4; 0x6000 (135°) → 0x2D41 ±4.
- Start_i pulsed again 5 cycles into a run with a different angle → ignored: one Done_o only, result from the first angle.
- Rst_i=0 mid-RUN → Sine_o=0 and Done_o=0 next cycle, no Done_o later. A new start then completes normally.
- Sweep all 65536 angles back-to-back → every result within ±4 LSB; Done_o is exactly one cycle wide each time.
